mp3player_soc_leds_pio: RTL and testbench
=========================================

// Module: mp3player_soc_leds_pio
// PURPOSE
//  Avalon-MM slave output PIO: CPU writes drive out_port (LEDs, codec control lines).
//  Write-side counterpart of the input key PIO.
//  Supports bit set and bit clear, plus timed auto-clearing pulses from one shared down-counter.
//  Sits on the SoC system interconnect next to the keys PIO.
// PARAMETERS
//  DATA_WIDTH      8          width of out_port and of the data/pulse registers (1..32)
//  CNT_WIDTH       24         width of the pulse-length register and the pulse counter
//  RESET_VALUE     0          out_port/data value after reset
//  PULSE_LEN_RST   49999      PULSE_LEN value after reset (1 ms at 50 MHz)
// PORTS
//  clk        in   1           system clock
//  reset      in   1           asynchronous, active-high reset
//  address    in   3           word address within the slave
//  chipselect in   1           slave select
//  write_n    in   1           active-low write strobe, qualified by chipselect
//  writedata  in   32          write data; bits above DATA_WIDTH/CNT_WIDTH ignored
//  readdata   out  32          registered read data, zero-extended
//  out_port   out  DATA_WIDTH  driven output = data register
// BEHAVIOUR
//  Register map:
//   0 DATA R/W: write sets data = wd; pmask = 0.
//   1 PULSE_LEN R/W: length L.
//   2 PULSE W: data |= wd, pmask |= wd, cnt = L. Read returns pmask.
//   3 reserved: reads 0, writes ignored.
//   4 OUTSET W: data |= wd; pmask &= ~wd. Reads 0.
//   5 OUTCLEAR W: data &= ~wd; pmask &= ~wd. Reads 0.
//   6, 7 reserved: reads 0, writes ignored.
//  - Write occurs on a clk edge with chipselect=1 and write_n=0; effect visible on out_port next cycle.
//  - readdata is registered every cycle from the address mux, regardless of chipselect.
//    Read latency is 1 clk.
//  - Pulse counter:
//    - Each cycle with cnt != 0: cnt <= cnt - 1.
//    - Each cycle with cnt == 0 and pmask != 0: data &= ~pmask; pmask <= 0 (expiry).
//    - A PULSE write at edge T: bits high from T+1 for exactly L+1 cycles; L=0 gives 1 cycle.
//  - Retrigger: a PULSE write while a pulse is active reloads cnt = L.
//    The new bits are ORed into pmask, so all pending bits expire together at the new end time.
//  - Simultaneous bus write and expiry in the same cycle: expiry is applied first, then the write.
//    The write always wins; e.g. a PULSE write at the expiry cycle leaves its bits set and starts a new count.
//  - A PULSE_LEN write during an active pulse does not affect cnt; it takes effect on the next PULSE write.
//  - pmask bits never exceed data bits: a bit in pmask is always 1 in data.
//  - Reset values: data=RESET_VALUE, out_port=RESET_VALUE, pmask=0, cnt=0, L=PULSE_LEN_RST, readdata=0.
//  - Reset mid-pulse: all state returns to reset values immediately (async); no expiry follows.
//  - No backpressure: waitrequest is not provided; every access completes in one cycle.
// TESTING
//  1 Reset: assert reset mid-cycle -> out_port=0 and readdata=0 immediately.
//    After release, a read of addr1 returns 49999.
//  2 DATA: write 0xA5 to addr0 -> out_port=0xA5 next cycle; read addr0 -> readdata=0x000000A5 one clk later.
//  3 Set/clear: DATA=0x0F, OUTSET 0x30 -> 0x3F; OUTCLEAR 0x03 -> 0x3C.
//    Reads of addr4 and addr5 return 0.
//  4 Pulse: PULSE_LEN=3, PULSE 0x80 at edge T -> out_port[7]=1 for cycles T+1..T+4, 0 at T+5.
//    Read addr2 returns 0x80 during the pulse, 0 after.
//  5 Retrigger/override:
//    - L=3, PULSE 0x01 at T, PULSE 0x02 at T+2 -> both bits clear together at T+7.
//    - Separate run: OUTSET 0x01 during a pulse -> bit 0 stays 1 after expiry.
//  6 Collision/reset: PULSE write landing on the expiry cycle -> bits stay set and a new L+1 window starts.
//    reset asserted mid-pulse -> out_port=0, pmask=0, no late clear glitch.

Source files
------------

// File: rtl/mp3player_soc_leds_pio.sv
// Avalon-MM output PIO driving LEDs and codec control lines.
// Supports direct write, bit set/clear, and timed auto-clearing pulses from one shared counter.
module mp3player_soc_leds_pio #(
  parameter int unsigned DATA_WIDTH    = 8,
  parameter int unsigned CNT_WIDTH     = 24,
  parameter int unsigned RESET_VALUE   = 0,
  parameter int unsigned PULSE_LEN_RST = 49999
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [2:0]            address,
  input  logic                  chipselect,
  input  logic                  write_n,
  input  logic [31:0]           writedata,
  output logic [31:0]           readdata,
  output logic [DATA_WIDTH-1:0] out_port
);

  localparam logic [2:0] ADDR_DATA      = 3'd0;
  localparam logic [2:0] ADDR_PULSE_LEN = 3'd1;
  localparam logic [2:0] ADDR_PULSE     = 3'd2;
  localparam logic [2:0] ADDR_OUTSET    = 3'd4;
  localparam logic [2:0] ADDR_OUTCLEAR  = 3'd5;

  logic [DATA_WIDTH-1:0] data, data_nxt, data_exp;
  logic [DATA_WIDTH-1:0] pmask, pmask_nxt, pmask_exp;
  logic [CNT_WIDTH-1:0]  cnt, cnt_nxt;
  logic [CNT_WIDTH-1:0]  plen, plen_nxt;
  logic [31:0]           rd_nxt;
  logic                  wr_en;
  logic                  expire;
  logic [DATA_WIDTH-1:0] wd;

  assign wr_en  = chipselect & ~write_n;
  assign wd     = writedata[DATA_WIDTH-1:0];
  assign expire = (cnt == '0) && (pmask != '0);

  // Expiry is resolved first so that a concurrent bus write always overrides it.
  always_comb begin
    data_exp  = expire ? (data & ~pmask) : data;
    pmask_exp = expire ? '0 : pmask;
    data_nxt  = data_exp;
    pmask_nxt = pmask_exp;
    cnt_nxt   = (cnt != '0) ? (cnt - CNT_WIDTH'(1)) : cnt;
    plen_nxt  = plen;
    if (wr_en) begin
      case (address)
        ADDR_DATA: begin
          data_nxt  = wd;
          pmask_nxt = '0;
        end
        ADDR_PULSE_LEN: plen_nxt = writedata[CNT_WIDTH-1:0];
        ADDR_PULSE: begin
          data_nxt  = data_exp | wd;
          pmask_nxt = pmask_exp | wd;
          cnt_nxt   = plen;
        end
        ADDR_OUTSET: begin
          data_nxt  = data_exp | wd;
          pmask_nxt = pmask_exp & ~wd;
        end
        ADDR_OUTCLEAR: begin
          data_nxt  = data_exp & ~wd;
          pmask_nxt = pmask_exp & ~wd;
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    rd_nxt = '0;
    case (address)
      ADDR_DATA:      rd_nxt = 32'(data);
      ADDR_PULSE_LEN: rd_nxt = 32'(plen);
      ADDR_PULSE:     rd_nxt = 32'(pmask);
      default:        rd_nxt = '0;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      data     <= DATA_WIDTH'(RESET_VALUE);
      pmask    <= '0;
      cnt      <= '0;
      plen     <= CNT_WIDTH'(PULSE_LEN_RST);
      readdata <= '0;
    end else begin
      data     <= data_nxt;
      pmask    <= pmask_nxt;
      cnt      <= cnt_nxt;
      plen     <= plen_nxt;
      readdata <= rd_nxt;
    end
  end

  assign out_port = data;

endmodule

// File: tb/tb_mp3player_soc_leds_pio.sv
// Directed bench for the LED output PIO: register map, set/clear, pulse timing, retrigger, collision, reset.
module tb_mp3player_soc_leds_pio;

  logic        clk;
  logic        reset;
  logic [2:0]  address;
  logic        chipselect;
  logic        write_n;
  logic [31:0] writedata;
  logic [31:0] readdata;
  logic [7:0]  out_port;

  int checks;
  int errors;

  mp3player_soc_leds_pio dut (
    .clk        (clk),
    .reset      (reset),
    .address    (address),
    .chipselect (chipselect),
    .write_n    (write_n),
    .writedata  (writedata),
    .readdata   (readdata),
    .out_port   (out_port)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Called at a negedge; the write lands on the following posedge and the task
  // returns at the next negedge, where out_port already shows the effect.
  task automatic bus_write(input logic [2:0] a, input logic [31:0] d);
    address    = a;
    writedata  = d;
    chipselect = 1'b1;
    write_n    = 1'b0;
    @(negedge clk);
    chipselect = 1'b0;
    write_n    = 1'b1;
  endtask

  task automatic bus_read(input logic [2:0] a, output logic [31:0] d);
    address = a;
    @(negedge clk);
    d = readdata;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) @(negedge clk);
  endtask

  task automatic test_reset;
    logic [31:0] rd;
    checks++;
    if (out_port !== 8'h00) begin
      errors++;
      $display("FAIL reset_out: got %h expected %h", out_port, 8'h00);
    end
    checks++;
    if (readdata !== 32'h0) begin
      errors++;
      $display("FAIL reset_readdata: got %h expected %h", readdata, 32'h0);
    end
    bus_write(3'd0, 32'h5A);
    address = 3'd0;
    @(negedge clk);
    #2 reset = 1'b1;
    #1;
    checks++;
    if (out_port !== 8'h00) begin
      errors++;
      $display("FAIL reset_async_out: got %h expected %h", out_port, 8'h00);
    end
    checks++;
    if (readdata !== 32'h0) begin
      errors++;
      $display("FAIL reset_async_rd: got %h expected %h", readdata, 32'h0);
    end
    @(negedge clk);
    reset = 1'b0;
    bus_read(3'd1, rd);
    checks++;
    if (rd !== 32'd49999) begin
      errors++;
      $display("FAIL reset_pulse_len: got %0d expected %0d", rd, 49999);
    end
  endtask

  task automatic test_data;
    logic [31:0] rd;
    bus_write(3'd0, 32'hFFFF_FFA5);
    checks++;
    if (out_port !== 8'hA5) begin
      errors++;
      $display("FAIL data_out: got %h expected %h", out_port, 8'hA5);
    end
    bus_read(3'd0, rd);
    checks++;
    if (rd !== 32'h0000_00A5) begin
      errors++;
      $display("FAIL data_read: got %h expected %h", rd, 32'h0000_00A5);
    end
    bus_write(3'd3, 32'hFF);
    checks++;
    if (out_port !== 8'hA5) begin
      errors++;
      $display("FAIL reserved_write: got %h expected %h", out_port, 8'hA5);
    end
  endtask

  task automatic test_set_clear;
    logic [31:0] rd;
    bus_write(3'd0, 32'h0F);
    bus_write(3'd4, 32'h30);
    checks++;
    if (out_port !== 8'h3F) begin
      errors++;
      $display("FAIL outset: got %h expected %h", out_port, 8'h3F);
    end
    bus_write(3'd5, 32'h03);
    checks++;
    if (out_port !== 8'h3C) begin
      errors++;
      $display("FAIL outclear: got %h expected %h", out_port, 8'h3C);
    end
    bus_read(3'd4, rd);
    checks++;
    if (rd !== 32'h0) begin
      errors++;
      $display("FAIL read_outset: got %h expected %h", rd, 32'h0);
    end
    bus_read(3'd5, rd);
    checks++;
    if (rd !== 32'h0) begin
      errors++;
      $display("FAIL read_outclear: got %h expected %h", rd, 32'h0);
    end
  endtask

  task automatic test_pulse;
    bus_write(3'd0, 32'h00);
    bus_write(3'd1, 32'd3);
    bus_write(3'd2, 32'h80);
    // now in cycle T+1; address stays on PULSE so readdata tracks pmask
    for (int k = 1; k <= 4; k++) begin
      checks++;
      if (out_port[7] !== 1'b1) begin
        errors++;
        $display("FAIL pulse_high cyc%0d: got %b expected 1", k, out_port[7]);
      end
      if (k == 2) begin
        checks++;
        if (readdata !== 32'h80) begin
          errors++;
          $display("FAIL pulse_pmask_active: got %h expected %h", readdata, 32'h80);
        end
      end
      @(negedge clk);
    end
    checks++;
    if (out_port[7] !== 1'b0) begin
      errors++;
      $display("FAIL pulse_end: got %b expected 0", out_port[7]);
    end
    @(negedge clk);
    checks++;
    if (readdata !== 32'h0) begin
      errors++;
      $display("FAIL pulse_pmask_after: got %h expected %h", readdata, 32'h0);
    end
    bus_write(3'd1, 32'd0);
    bus_write(3'd2, 32'h01);
    checks++;
    if (out_port !== 8'h01) begin
      errors++;
      $display("FAIL pulse_len0_high: got %h expected %h", out_port, 8'h01);
    end
    @(negedge clk);
    checks++;
    if (out_port !== 8'h00) begin
      errors++;
      $display("FAIL pulse_len0_end: got %h expected %h", out_port, 8'h00);
    end
  endtask

  task automatic test_retrigger;
    logic [31:0] rd;
    bus_write(3'd0, 32'h00);
    bus_write(3'd1, 32'd3);
    bus_write(3'd2, 32'h01);
    @(negedge clk);
    bus_write(3'd2, 32'h02);
    for (int k = 3; k <= 6; k++) begin
      checks++;
      if (out_port !== 8'h03) begin
        errors++;
        $display("FAIL retrig_high cyc%0d: got %h expected %h", k, out_port, 8'h03);
      end
      @(negedge clk);
    end
    checks++;
    if (out_port !== 8'h00) begin
      errors++;
      $display("FAIL retrig_end: got %h expected %h", out_port, 8'h00);
    end
    bus_write(3'd2, 32'h01);
    bus_write(3'd4, 32'h01);
    idle(6);
    checks++;
    if (out_port !== 8'h01) begin
      errors++;
      $display("FAIL outset_override: got %h expected %h", out_port, 8'h01);
    end
    bus_read(3'd2, rd);
    checks++;
    if (rd !== 32'h0) begin
      errors++;
      $display("FAIL override_pmask: got %h expected %h", rd, 32'h0);
    end
  endtask

  task automatic test_collision;
    bus_write(3'd0, 32'h00);
    bus_write(3'd1, 32'd3);
    bus_write(3'd2, 32'h04);
    idle(3);
    bus_write(3'd2, 32'h04);
    for (int k = 0; k < 4; k++) begin
      checks++;
      if (out_port !== 8'h04) begin
        errors++;
        $display("FAIL collision_high cyc%0d: got %h expected %h", k, out_port, 8'h04);
      end
      @(negedge clk);
    end
    checks++;
    if (out_port !== 8'h00) begin
      errors++;
      $display("FAIL collision_end: got %h expected %h", out_port, 8'h00);
    end
  endtask

  task automatic test_reset_mid_pulse;
    logic [31:0] rd;
    bus_write(3'd1, 32'd3);
    bus_write(3'd2, 32'h10);
    #2 reset = 1'b1;
    #1;
    checks++;
    if (out_port !== 8'h00) begin
      errors++;
      $display("FAIL reset_mid_out: got %h expected %h", out_port, 8'h00);
    end
    @(negedge clk);
    reset = 1'b0;
    bus_write(3'd4, 32'h10);
    idle(6);
    checks++;
    if (out_port !== 8'h10) begin
      errors++;
      $display("FAIL reset_no_late_clear: got %h expected %h", out_port, 8'h10);
    end
    bus_read(3'd2, rd);
    checks++;
    if (rd !== 32'h0) begin
      errors++;
      $display("FAIL reset_mid_pmask: got %h expected %h", rd, 32'h0);
    end
  endtask

  initial begin
    checks     = 0;
    errors     = 0;
    reset      = 1'b1;
    address    = 3'd0;
    chipselect = 1'b0;
    write_n    = 1'b1;
    writedata  = '0;
    idle(2);
    reset = 1'b0;
    @(negedge clk);
    test_reset();
    test_data();
    test_set_clear();
    test_pulse();
    test_retrigger();
    test_collision();
    test_reset_mid_pulse();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
